// File: rtl/seq_pkg.sv
// Shared definitions for the "1011" pattern transmitter and its matching detector.
// Holds the state encodings plus the default pattern length and value, so both ends agree.
// No logic; types and constants only.
package seq_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
    localparam logic [1:0] ST_GAP_ENC   = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_GAP   = ST_GAP_ENC,
        ST_DONE  = ST_DONE_ENC
    } seq_state_t;

    localparam int                     SEQ_PAT_W   = 4;
    localparam logic [SEQ_PAT_W-1:0]   SEQ_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero, so it never wraps.
// Latency: load/decrement take effect at the next clock edge; zero is decoded from the count register.
// No backpressure: load has priority over dec, and dec is ignored at zero.
module seq_down_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Count register: load wins, otherwise step down until zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial transmitter: shifts PATTERN out MSB first, repeated repeat_cnt times (optional zero gaps: SEQ_GAP_EN).
// Latency: start sampled at edge N -> first bit in cycle N+1, done pulse the cycle after the last bit.
// No backpressure: start is only honoured in IDLE; requests while busy or in DONE are dropped.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W   = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
    parameter int               CNT_W   = 8,
    parameter int               GAP_LEN = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             sequence_out,
    output logic             busy,
    output logic             frame_start,
    output logic             done
);

    localparam int               IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

    if (PAT_W < 2) begin : g_bad_pat_w
        $error("seq_pattern_tx: PAT_W must be at least 2");
    end
    if (GAP_LEN < 1) begin : g_bad_gap_len
        $error("seq_pattern_tx: GAP_LEN must be at least 1");
    end

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             rep_load, rep_dec, rep_zero;
    logic             seq_d, busy_d, frame_start_d, done_d;

    // rep holds "repetitions still to go after the current one", so zero means this is the last pass.
    seq_down_counter #(.W(CNT_W)) u_rep_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (rep_load),
        .dec      (rep_dec),
        .load_val (repeat_cnt - CNT_W'(1)),
        .zero     (rep_zero)
    );

`ifdef SEQ_GAP_EN
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN + 1) : 1;

    logic gap_load, gap_dec, gap_zero;

    // gap holds "gap cycles remaining after this one", loaded on GAP entry.
    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (gap_load),
        .dec      (gap_dec),
        .load_val (GAP_W'(GAP_LEN - 1)),
        .zero     (gap_zero)
    );
`endif

    // Next-state, bit index and counter controls, plus the output values for the next cycle.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        rep_load  = 1'b0;
        rep_dec   = 1'b0;
`ifdef SEQ_GAP_EN
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && (repeat_cnt != '0)) begin
                    state_d   = ST_SHIFT;
                    bit_idx_d = IDX_MAX;
                    rep_load  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_idx_q == '0) begin
                    if (rep_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        rep_dec   = 1'b1;
                        bit_idx_d = IDX_MAX;
`ifdef SEQ_GAP_EN
                        state_d   = ST_GAP;
                        gap_load  = 1'b1;
`endif
                    end
                end else begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end
            end
`ifdef SEQ_GAP_EN
            ST_GAP: begin
                if (gap_zero) begin
                    state_d = ST_SHIFT;
                end else begin
                    gap_dec = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are computed from the next state so they register alongside it (pure Moore timing).
        seq_d         = (state_d == ST_SHIFT) ? PATTERN[bit_idx_d] : 1'b0;
        busy_d        = (state_d == ST_SHIFT) || (state_d == ST_GAP);
        frame_start_d = (state_d == ST_SHIFT) && (bit_idx_d == IDX_MAX);
        done_d        = (state_d == ST_DONE);
    end

    // State, bit index and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            sequence_out <= 1'b0;
            busy         <= 1'b0;
            frame_start  <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            sequence_out <= seq_d;
            busy         <= busy_d;
            frame_start  <= frame_start_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle output traces packed MSB-first into words.
// Word bit k (from the left) is the output in cycle N+1+k, where N is the edge that sampled start.
// Also covers SEQ_GAP_EN when the macro is defined for the build.
module tb_seq_pattern_tx;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] repeat_cnt = 8'd0;
    logic       sequence_out, busy, frame_start, done;

    int vec_cnt = 0;
    int err_cnt = 0;

    seq_pattern_tx dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .repeat_cnt   (repeat_cnt),
        .sequence_out (sequence_out),
        .busy         (busy),
        .frame_start  (frame_start),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {sequence_out, busy, frame_start, done};
    endfunction

    // Present start for exactly one edge (edge N); afterwards we sit in cycle N+1.
    task automatic pulse_start(input logic [7:0] rep);
        start      = 1'b1;
        repeat_cnt = rep;
        tick();
        start      = 1'b0;
    endtask

    // Sample n cycles; optionally re-pulse start (with a different count) during sample inj_at.
    task automatic capture(input int n, input int inj_at,
                           output logic [31:0] sq, output logic [31:0] bs,
                           output logic [31:0] fs, output logic [31:0] dn,
                           output int hits);
        logic [3:0] hist;
        sq = '0; bs = '0; fs = '0; dn = '0; hits = 0; hist = '0;
        for (int k = 0; k < n; k++) begin
            sq   = {sq[30:0], sequence_out};
            bs   = {bs[30:0], busy};
            fs   = {fs[30:0], frame_start};
            dn   = {dn[30:0], done};
            hist = {hist[2:0], sequence_out};
            if (hist == 4'b1011) hits++;
            if (k == inj_at) begin
                start      = 1'b1;
                repeat_cnt = 8'd5;
            end
            tick();
            start = 1'b0;
        end
    endtask

    logic [31:0] sq, bs, fs, dn;
    int          hits;

    initial begin
        // Reset held for 3 cycles, then 5 idle cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_hold%0d", i), 32'(outs()), 32'h0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle%0d", i), 32'(outs()), 32'h0);
        end

        // Single frame.
        pulse_start(8'd1);
        capture(6, -1, sq, bs, fs, dn, hits);
        chk("single_seq",  sq, 32'b101100);
        chk("single_busy", bs, 32'b111100);
        chk("single_fs",   fs, 32'b100000);
        chk("single_done", dn, 32'b000010);

        // Three repetitions back-to-back (default build) or with gaps.
        pulse_start(8'd3);
`ifdef SEQ_GAP_EN
        capture(18, -1, sq, bs, fs, dn, hits);
        chk("rep3_seq",  sq, 32'b101100101100101100);
        chk("rep3_busy", bs, 32'b111111111111111100);
        chk("rep3_fs",   fs, 32'b100000100000100000);
        chk("rep3_done", dn, 32'b000000000000000010);
`else
        capture(14, -1, sq, bs, fs, dn, hits);
        chk("rep3_seq",  sq, 32'b10111011101100);
        chk("rep3_busy", bs, 32'b11111111111100);
        chk("rep3_fs",   fs, 32'b10001000100000);
        chk("rep3_done", dn, 32'b00000000000010);
`endif
        chk("rep3_detect", 32'(hits), 32'd3);

        // start with repeat_cnt=0 is ignored.
        pulse_start(8'd0);
        capture(6, -1, sq, bs, fs, dn, hits);
        chk("zero_seq",  sq, 32'h0);
        chk("zero_busy", bs, 32'h0);
        chk("zero_done", dn, 32'h0);

        // Second start at N+2 of a running frame changes nothing.
        pulse_start(8'd1);
        capture(8, 1, sq, bs, fs, dn, hits);
        chk("inj_seq",  sq, 32'b10110000);
        chk("inj_busy", bs, 32'b11110000);
        chk("inj_done", dn, 32'b00001000);

        // Reset during bit 2: outputs clear asynchronously, no done afterwards.
        pulse_start(8'd1);
        tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("abort_async", 32'(outs()), 32'h0);
        tick();
        reset_n = 1'b1;
        capture(6, -1, sq, bs, fs, dn, hits);
        chk("abort_quiet", bs | dn | sq, 32'h0);
        pulse_start(8'd1);
        capture(6, -1, sq, bs, fs, dn, hits);
        chk("post_abort_seq",  sq, 32'b101100);
        chk("post_abort_done", dn, 32'b000010);

        // Two repetitions: back-to-back, or "1011 00 1011" with SEQ_GAP_EN (done at N+11).
        pulse_start(8'd2);
`ifdef SEQ_GAP_EN
        capture(12, -1, sq, bs, fs, dn, hits);
        chk("rep2_seq",  sq, 32'b101100101100);
        chk("rep2_busy", bs, 32'b111111111100);
        chk("rep2_fs",   fs, 32'b100000100000);
        chk("rep2_done", dn, 32'b000000000010);
`else
        capture(10, -1, sq, bs, fs, dn, hits);
        chk("rep2_seq",  sq, 32'b1011101100);
        chk("rep2_busy", bs, 32'b1111111100);
        chk("rep2_fs",   fs, 32'b1000100000);
        chk("rep2_done", dn, 32'b0000000010);
`endif

        // Maximum repetition count: no wrap, done after exactly 255 passes.
        begin
            int done_at;
            int busy_cyc;
            done_at  = -1;
            busy_cyc = 0;
            pulse_start(8'd255);
            for (int k = 0; k < 2000 && done_at < 0; k++) begin
                if (busy) busy_cyc++;
                if (done) done_at = k;
                tick();
            end
`ifdef SEQ_GAP_EN
            chk("max_done_at", 32'(done_at), 32'd1528);
            chk("max_busy",    32'(busy_cyc), 32'd1528);
`else
            chk("max_done_at", 32'(done_at), 32'd1020);
            chk("max_busy",    32'(busy_cyc), 32'd1020);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
